// File: rtl/busca_instrucao.sv
// ---------------------------------------------------------------------------
// busca_instrucao
// Instruction fetch stage. Reads the current PC, issues a request to the
// instruction memory, hands the returned word to decode and tells the PC
// register which value to load next. Branch/jump redirects from later
// stages override the sequential next-PC, and a memory that never answers
// is retried after a bounded wait.
//
// Parameters
//   LARG_INSTR   instruction word width in bits
//   TIMEOUT      WAIT cycles without mem_ack before giving up (2..255)
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   SaidaPC      current PC value from the PC register
//   EntradaPC    next PC value for the PC register
//   EscPC        PC write enable, single-cycle pulse
//   mem_req      instruction memory request
//   mem_addr     instruction memory address
//   mem_ack      memory data valid
//   mem_data     memory read data
//   InstrOut     fetched instruction
//   InstrValid   InstrOut valid towards decode
//   InstrReady   decode accepts InstrOut
//   DesvioValido branch/jump redirect request
//   DesvioAlvo   redirect target
//   ErroBusca    sticky memory timeout flag
// ---------------------------------------------------------------------------
module busca_instrucao #(
    parameter int LARG_INSTR = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            SaidaPC,
    output logic [7:0]            EntradaPC,
    output logic                  EscPC,
    output logic                  mem_req,
    output logic [7:0]            mem_addr,
    input  logic                  mem_ack,
    input  logic [LARG_INSTR-1:0] mem_data,
    output logic [LARG_INSTR-1:0] InstrOut,
    output logic                  InstrValid,
    input  logic                  InstrReady,
    input  logic                  DesvioValido,
    input  logic [7:0]            DesvioAlvo,
    output logic                  ErroBusca
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Counter value seen at the end of the last ack-less WAIT cycle allowed.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t                  state, state_nxt;
    logic [7:0]              count, count_nxt;
    logic                    pend_valid, pend_valid_nxt;
    logic [7:0]              pend_alvo, pend_alvo_nxt;
    logic [7:0]              entrada_nxt, addr_nxt;
    logic                    esc_nxt, req_nxt, valid_nxt, erro_nxt;
    logic [LARG_INSTR-1:0]   instr_nxt;
    logic                    redirect;
    logic [7:0]              alvo;

    // Next-state and next-output logic. Every output is a register, so this
    // block computes the value each register takes at the next edge. A
    // redirect arriving in the same cycle as the pending one is newer and
    // therefore wins; EscPC defaults low so it can only ever pulse.
    always_comb begin
        redirect       = DesvioValido | pend_valid;
        alvo           = DesvioValido ? DesvioAlvo : pend_alvo;
        state_nxt      = state;
        count_nxt      = count;
        pend_valid_nxt = pend_valid;
        pend_alvo_nxt  = pend_alvo;
        entrada_nxt    = EntradaPC;
        addr_nxt       = mem_addr;
        esc_nxt        = 1'b0;
        req_nxt        = mem_req;
        valid_nxt      = InstrValid;
        instr_nxt      = InstrOut;
        erro_nxt       = ErroBusca;

        case (state)
            IDLE: begin
                if (DesvioValido) begin
                    entrada_nxt = DesvioAlvo;
                    esc_nxt     = 1'b1;
                end else if (!EscPC) begin
                    // SaidaPC is only trusted once the PC register has
                    // absorbed the previous write.
                    addr_nxt       = SaidaPC;
                    req_nxt        = 1'b1;
                    count_nxt      = 8'd0;
                    pend_valid_nxt = 1'b0;
                    state_nxt      = WAIT;
                end
            end

            WAIT: begin
                if (DesvioValido) begin
                    pend_valid_nxt = 1'b1;
                    pend_alvo_nxt  = DesvioAlvo;
                end
                if (mem_ack) begin
                    req_nxt        = 1'b0;
                    esc_nxt        = 1'b1;
                    pend_valid_nxt = 1'b0;
                    if (redirect) begin
                        // The fetched word belongs to the wrong path.
                        entrada_nxt = alvo;
                        state_nxt   = IDLE;
                    end else begin
                        instr_nxt   = mem_data;
                        valid_nxt   = 1'b1;
                        entrada_nxt = mem_addr + 8'd1;
                        state_nxt   = HOLD;
                    end
                end else if (count == TIMEOUT_LAST) begin
                    erro_nxt       = 1'b1;
                    req_nxt        = 1'b0;
                    pend_valid_nxt = 1'b0;
                    state_nxt      = IDLE;
                    if (redirect) begin
                        entrada_nxt = alvo;
                        esc_nxt     = 1'b1;
                    end
                end else begin
                    count_nxt = count + 8'd1;
                end
            end

            HOLD: begin
                if (DesvioValido) begin
                    valid_nxt   = 1'b0;
                    entrada_nxt = DesvioAlvo;
                    esc_nxt     = 1'b1;
                    state_nxt   = IDLE;
                end else if (InstrReady) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset returns everything to an idle,
    // request-free fetch unit so any in-flight memory answer is ignored.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= 8'd0;
            pend_valid <= 1'b0;
            pend_alvo  <= 8'd0;
            EntradaPC  <= 8'd0;
            mem_addr   <= 8'd0;
            EscPC      <= 1'b0;
            mem_req    <= 1'b0;
            InstrValid <= 1'b0;
            InstrOut   <= '0;
            ErroBusca  <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            pend_valid <= pend_valid_nxt;
            pend_alvo  <= pend_alvo_nxt;
            EntradaPC  <= entrada_nxt;
            mem_addr   <= addr_nxt;
            EscPC      <= esc_nxt;
            mem_req    <= req_nxt;
            InstrValid <= valid_nxt;
            InstrOut   <= instr_nxt;
            ErroBusca  <= erro_nxt;
        end
    end

endmodule

// File: tb/tb_busca_instrucao.sv
// ---------------------------------------------------------------------------
// tb_busca_instrucao
// Testbench for busca_instrucao. A table of fetch vectors is applied in a
// loop; each expected fetch result is queued when the fetch is started and
// popped when the DUT raises InstrValid. Hand-written sequences cover
// redirects, timeout/retry and reset in the middle of a request. The bench
// also models the PC register (SaidaPC loads EntradaPC on EscPC).
// ---------------------------------------------------------------------------
module tb_busca_instrucao;

    localparam int LW = 16;

    logic          clock;
    logic          reset;
    logic [7:0]    SaidaPC;
    logic [7:0]    EntradaPC;
    logic          EscPC;
    logic          mem_req;
    logic [7:0]    mem_addr;
    logic          mem_ack;
    logic [LW-1:0] mem_data;
    logic [LW-1:0] InstrOut;
    logic          InstrValid;
    logic          InstrReady;
    logic          DesvioValido;
    logic [7:0]    DesvioAlvo;
    logic          ErroBusca;

    busca_instrucao #(
        .LARG_INSTR(LW),
        .TIMEOUT   (15)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .SaidaPC     (SaidaPC),
        .EntradaPC   (EntradaPC),
        .EscPC       (EscPC),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .InstrOut    (InstrOut),
        .InstrValid  (InstrValid),
        .InstrReady  (InstrReady),
        .DesvioValido(DesvioValido),
        .DesvioAlvo  (DesvioAlvo),
        .ErroBusca   (ErroBusca)
    );

    typedef struct {
        logic [7:0]    addr;
        logic [LW-1:0] instr;
        logic [7:0]    nextPc;
    } exp_t;

    typedef struct {
        logic [7:0]    pc;
        logic [LW-1:0] data;
        int            ackDelay;
        int            readyDelay;
        logic [7:0]    expNext;
    } vec_t;

    exp_t sbQueue[$];
    vec_t vecs[5];
    int   riseCyc[5];
    int   applied     = 0;
    int   miscompares = 0;
    int   cycle       = 0;
    int   validRise   = 0;
    logic prevValid   = 1'b0;

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case a sequence wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expectFetch(input logic [7:0] a, input logic [LW-1:0] d, input logic [7:0] n);
        exp_t e;
        e.addr   = a;
        e.instr  = d;
        e.nextPc = n;
        sbQueue.push_back(e);
    endtask

    // One clock cycle: sample at the falling edge, score any new
    // instruction, then update the PC register model.
    task automatic tick();
        exp_t e;
        @(negedge clock);
        cycle++;
        if (reset && InstrValid && !prevValid) begin
            if (sbQueue.size() == 0) begin
                applied++;
                miscompares++;
                $display("[TB] FAIL unexpected InstrValid: got 1, expected 0");
            end else begin
                e = sbQueue.pop_front();
                check("sb InstrOut", 32'(InstrOut), 32'(e.instr));
                check("sb EntradaPC", 32'(EntradaPC), 32'(e.nextPc));
                check("sb mem_addr", 32'(mem_addr), 32'(e.addr));
                check("sb EscPC", 32'(EscPC), 32'd1);
            end
            validRise = cycle;
        end
        prevValid = InstrValid;
        if (EscPC) SaidaPC = EntradaPC;
    endtask

    task automatic waitReq();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (mem_req) seen = 1'b1;
        end
        check("mem_req issued", 32'(seen), 32'd1);
    endtask

    // Completes a fetch whose request is already visible on mem_req.
    task automatic applyStimulus(input logic [LW-1:0] data, input int ackDelay, input int readyDelay);
        int pulses = 0;
        mem_data = data;
        for (int i = 0; i < ackDelay; i++) begin
            tick();
            check("mem_req held", 32'(mem_req), 32'd1);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack  = 1'b0;
        mem_data = ~data;
        check("InstrValid latency", 32'(InstrValid), 32'd1);
        pulses += int'(EscPC);
        for (int i = 0; i < readyDelay; i++) begin
            tick();
            check("InstrOut stable", 32'(InstrOut), 32'(data));
            check("no mem_req in HOLD", 32'(mem_req), 32'd0);
            pulses += int'(EscPC);
        end
        InstrReady = 1'b1;
        tick();
        InstrReady = 1'b0;
        pulses += int'(EscPC);
        check("InstrValid cleared", 32'(InstrValid), 32'd0);
        check("EscPC pulse count", 32'(pulses), 32'd1);
    endtask

    task automatic checkOutput(input string tag);
        check({tag, " mem_req"}, 32'(mem_req), 32'd0);
        check({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, " EscPC"}, 32'(EscPC), 32'd0);
        check({tag, " EntradaPC"}, 32'(EntradaPC), 32'd0);
        check({tag, " InstrValid"}, 32'(InstrValid), 32'd0);
        check({tag, " InstrOut"}, 32'(InstrOut), 32'd0);
        check({tag, " ErroBusca"}, 32'(ErroBusca), 32'd0);
    endtask

    initial begin
        int hi;
        vecs[0] = '{8'h10, 16'hA5C3, 1, 0, 8'h11};
        vecs[1] = '{8'hFF, 16'h1234, 1, 0, 8'h00};
        vecs[2] = '{8'h7F, 16'hBEEF, 3, 5, 8'h80};
        vecs[3] = '{8'h00, 16'h0001, 0, 2, 8'h01};
        vecs[4] = '{8'h3C, 16'hFFFF, 1, 0, 8'h3D};

        reset        = 1'b0;
        SaidaPC      = 8'h00;
        mem_ack      = 1'b0;
        mem_data     = '0;
        InstrReady   = 1'b0;
        DesvioValido = 1'b0;
        DesvioAlvo   = 8'h00;
        tick();
        tick();
        checkOutput("reset");

        $display("[TB] table-driven fetches");
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            SaidaPC = vecs[i].pc;
            expectFetch(vecs[i].pc, vecs[i].data, vecs[i].expNext);
            waitReq();
            check("request address", 32'(mem_addr), 32'(vecs[i].pc));
            applyStimulus(vecs[i].data, vecs[i].ackDelay, vecs[i].readyDelay);
            riseCyc[i] = validRise;
        end
        check("fetch period", 32'(riseCyc[1] - riseCyc[0]), 32'd4);

        $display("[TB] redirect during WAIT");
        SaidaPC = 8'h50;
        waitReq();
        check("WAIT addr", 32'(mem_addr), 32'h50);
        DesvioValido = 1'b1;
        DesvioAlvo   = 8'h40;
        tick();
        DesvioValido = 1'b0;
        check("req kept after redirect", 32'(mem_req), 32'd1);
        tick();
        tick();
        mem_data = 16'hDEAD;
        mem_ack  = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("discard InstrValid", 32'(InstrValid), 32'd0);
        check("redirect EntradaPC", 32'(EntradaPC), 32'h40);
        check("redirect EscPC", 32'(EscPC), 32'd1);
        check("redirect req dropped", 32'(mem_req), 32'd0);
        tick();
        check("redirect EscPC single", 32'(EscPC), 32'd0);
        check("no req while PC loads", 32'(mem_req), 32'd0);
        expectFetch(8'h40, 16'h0F0F, 8'h41);
        waitReq();
        check("fetch from target", 32'(mem_addr), 32'h40);
        applyStimulus(16'h0F0F, 1, 0);

        $display("[TB] newer redirect overwrites pending");
        waitReq();
        check("seq addr after target", 32'(mem_addr), 32'h41);
        DesvioValido = 1'b1;
        DesvioAlvo   = 8'h70;
        tick();
        DesvioAlvo = 8'h74;
        tick();
        DesvioValido = 1'b0;
        mem_ack      = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("overwrite EntradaPC", 32'(EntradaPC), 32'h74);
        check("overwrite InstrValid", 32'(InstrValid), 32'd0);

        $display("[TB] redirect with ack in same cycle");
        waitReq();
        check("addr after overwrite", 32'(mem_addr), 32'h74);
        DesvioValido = 1'b1;
        DesvioAlvo   = 8'h90;
        mem_ack      = 1'b1;
        tick();
        DesvioValido = 1'b0;
        mem_ack      = 1'b0;
        check("same-cycle EntradaPC", 32'(EntradaPC), 32'h90);
        check("same-cycle InstrValid", 32'(InstrValid), 32'd0);
        check("same-cycle EscPC", 32'(EscPC), 32'd1);

        $display("[TB] redirect during HOLD");
        expectFetch(8'h90, 16'h1357, 8'h91);
        waitReq();
        mem_data = 16'h1357;
        mem_ack  = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("HOLD entered", 32'(InstrValid), 32'd1);
        DesvioValido = 1'b1;
        DesvioAlvo   = 8'h20;
        InstrReady   = 1'b1;
        tick();
        DesvioValido = 1'b0;
        InstrReady   = 1'b0;
        check("HOLD redirect InstrValid", 32'(InstrValid), 32'd0);
        check("HOLD redirect EntradaPC", 32'(EntradaPC), 32'h20);
        check("HOLD redirect EscPC", 32'(EscPC), 32'd1);

        $display("[TB] memory timeout");
        waitReq();
        check("timeout addr", 32'(mem_addr), 32'h20);
        check("ErroBusca before", 32'(ErroBusca), 32'd0);
        hi = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!mem_req) break;
            hi++;
        end
        check("timeout req cycles", 32'(hi), 32'd15);
        check("ErroBusca set", 32'(ErroBusca), 32'd1);
        waitReq();
        check("retry addr", 32'(mem_addr), 32'h20);
        check("ErroBusca sticky", 32'(ErroBusca), 32'd1);

        $display("[TB] reset during WAIT");
        SaidaPC = 8'h33;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async reset");
        tick();
        reset   = 1'b1;
        mem_ack = 1'b1;
        expectFetch(8'h33, 16'h2468, 8'h34);
        tick();
        mem_ack = 1'b0;
        check("stale ack ignored", 32'(InstrValid), 32'd0);
        check("post-reset req", 32'(mem_req), 32'd1);
        check("post-reset addr", 32'(mem_addr), 32'h33);
        applyStimulus(16'h2468, 1, 0);

        check("scoreboard drained", 32'(sbQueue.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/busca_instrucao.md
BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

Interface
REQ-001 SHALL have parameter LARG_INSTR, default 16, instruction word width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum WAIT cycles without mem_ack before retry (legal 2..255).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have port SaidaPC  input  8  current PC value from the PC register.
REQ-006 SHALL have port EntradaPC  output  8  next PC value to the PC register.
REQ-007 SHALL have port EscPC  output  1  PC write enable, single-cycle pulse.
REQ-008 SHALL have port mem_req  output  1  instruction memory request.
REQ-009 SHALL have port mem_addr  output  8  instruction memory address.
REQ-010 SHALL have port mem_ack  input  1  memory data valid.
REQ-011 SHALL have port mem_data  input  LARG_INSTR  memory read data.
REQ-012 SHALL have port InstrOut  output  LARG_INSTR  fetched instruction.
REQ-013 SHALL have port InstrValid  output  1  InstrOut valid to decode.
REQ-014 SHALL have port InstrReady  input  1  decode accepts InstrOut.
REQ-015 SHALL have port DesvioValido  input  1  branch/jump redirect request.
REQ-016 SHALL have port DesvioAlvo  input  8  redirect target.
REQ-017 SHALL have port ErroBusca  output  1  sticky timeout flag.

Function
REQ-018 SHALL implement states IDLE, WAIT, HOLD; all outputs registered.
REQ-019 IDLE with EscPC=0 and DesvioValido=0 SHALL register mem_addr=SaidaPC, mem_req=1, clear timeout counter, go WAIT; no request SHALL issue in a cycle where EscPC=1.
REQ-020 WAIT SHALL hold mem_req=1 and mem_addr stable until mem_ack or timeout.
REQ-021 WAIT with mem_ack=1 and no pending redirect SHALL register InstrOut=mem_data, InstrValid=1, mem_req=0, EntradaPC=mem_addr+1 (mod 256, 8'hFF wraps to 8'h00), EscPC=1 for one cycle, go HOLD.
REQ-022 WAIT SHALL increment the timeout counter each cycle without mem_ack; on the TIMEOUT-th such cycle SHALL set ErroBusca=1, drive mem_req=0, go IDLE (retry same SaidaPC).
REQ-023 HOLD SHALL keep InstrValid=1 and InstrOut stable until InstrReady=1; on InstrValid&InstrReady SHALL clear InstrValid and go IDLE.
REQ-024 DesvioValido in IDLE SHALL register EntradaPC=DesvioAlvo, EscPC=1, stay IDLE without request.
REQ-025 DesvioValido in WAIT SHALL latch DesvioAlvo as pending; on the later mem_ack the data SHALL be discarded (InstrValid stays 0), EntradaPC=pending target, EscPC=1, go IDLE; a newer DesvioValido SHALL overwrite the pending target.
REQ-026 DesvioValido and mem_ack in the same WAIT cycle SHALL behave as REQ-025 with DesvioAlvo; redirect wins.
REQ-027 DesvioValido in HOLD SHALL clear InstrValid (even if InstrReady=1 that cycle), register EntradaPC=DesvioAlvo, EscPC=1, go IDLE.
REQ-028 Timeout with a pending redirect SHALL return to IDLE and apply the pending redirect per REQ-024 in the same transition.
REQ-029 Ack-to-InstrValid latency SHALL be 1 cycle; back-to-back fetch with InstrReady=1 and 1-cycle mem_ack SHALL sustain one instruction per 4 cycles.

Reset
REQ-030 reset=0 SHALL immediately force state IDLE, mem_req=0, mem_addr=0, EscPC=0, EntradaPC=0, InstrValid=0, InstrOut=0, ErroBusca=0, pending redirect cleared, counter=0.
REQ-031 Reset mid-WAIT SHALL abandon the request; a mem_ack arriving after reset release while in IDLE SHALL be ignored.
REQ-032 ErroBusca SHALL clear only on reset.

Verification
REQ-033 SaidaPC=8'h10, mem_ack 1 cycle after req, mem_data=16'hA5C3, InstrReady=1 -> mem_addr=8'h10, InstrOut=16'hA5C3 with InstrValid 1 cycle, EntradaPC=8'h11, EscPC one pulse.
REQ-034 SaidaPC=8'hFF fetch -> EntradaPC=8'h00.
REQ-035 InstrReady=0 for 5 cycles after InstrValid -> InstrOut stable, no new mem_req, EscPC pulses exactly once.
REQ-036 mem_ack never asserted, TIMEOUT=15 -> mem_req drops after 15 WAIT cycles, ErroBusca=1, re-request same address.
REQ-037 DesvioValido with DesvioAlvo=8'h40 during WAIT, ack 3 cycles later -> InstrValid stays 0, EntradaPC=8'h40, EscPC one pulse, next mem_addr=8'h40.
REQ-038 reset=0 asserted mid-WAIT then released -> all outputs at reset values, next fetch from current SaidaPC.
